// File: rtl/enc_home_pkg.sv
// Shared types and constants for the encoder homing controller.
package enc_home_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_RDY,
        CLR_Z,
        SEARCH,
        SETTLE,
        CALC,
        WR_LO,
        WR_HI,
        DONE,
        FAULT
    } state_t;

    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_TMO   = 2'b01;
    localparam logic [1:0] FLT_ENC   = 2'b10;
    localparam logic [1:0] FLT_ABORT = 2'b11;

    localparam logic       ADDR_LO = 1'b0;
    localparam logic       ADDR_HI = 1'b1;
    localparam logic [1:0] BE_ALL  = 2'b11;

    function automatic logic is_busy(input state_t s);
        return !((s == IDLE) || (s == DONE) || (s == FAULT));
    endfunction

endpackage

// File: rtl/enc_home_ctrl_hold_timer.sv
// Loadable down-counter; o_expire marks the last cycle of a hold of i_load_val cycles.
module hold_timer #(
    parameter int W = 24
) (
    input  logic         i_clk,
    input  logic         i_srst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end
    end

    // A load of 0 behaves like 1: the hold always lasts at least one cycle.
    assign o_expire = (r_cnt <= {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/enc_home_ctrl.sv
// Encoder homing sequencer: search for the index pulse, settle, then preset the counter over a 16-bit bus.
module enc_home_ctrl
    import enc_home_pkg::*;
#(
    parameter int          TIMEOUT_W  = 24,
    parameter int unsigned SETTLE_CYC = 256
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 search_dir,
    input  logic signed [31:0]   home_offset,
    input  logic [TIMEOUT_W-1:0] timeout_lim,
    input  logic                 enc_ready,
    input  logic                 enc_error,
    input  logic                 Z_flag,
    input  logic signed [31:0]   Z_pos,
    input  logic signed [31:0]   bidir_counter,
    output logic                 enc_ena,
    output logic                 enc_dir,
    output logic                 Z_clr,
    output logic                 motor_run,
    output logic                 addr,
    output logic [1:0]           be,
    output logic                 write,
    output logic [15:0]          data,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [1:0]           fault_code
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int CNT_W = (TIMEOUT_W > SET_W) ? TIMEOUT_W : SET_W;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_fault_code;
    logic [1:0]         w_code_next;
    logic               r_dir;
    logic               w_dir_next;
    logic signed [31:0] r_preset;
    logic signed [31:0] w_preset_calc;

    logic               r_enc_ena;
    logic               r_enc_dir;
    logic               r_z_clr;
    logic               r_motor_run;
    logic               r_addr;
    logic [1:0]         r_be;
    logic               r_write;
    logic [15:0]        r_data;
    logic               r_busy;
    logic               r_done;
    logic               r_fault;

    logic               w_expire;
    logic               w_tmr_load;
    logic               w_tmr_en;
    logic [CNT_W-1:0]   w_tmr_val;
    logic               w_enc_phase;
    logic               w_next_ena;
    logic               w_next_wr;

    assign w_preset_calc = home_offset + (bidir_counter - Z_pos);
    assign w_enc_phase   = (r_state == WAIT_RDY) || (r_state == CLR_Z) ||
                           (r_state == SEARCH)   || (r_state == SETTLE);

    // One timer serves both holds; it is reloaded on every entry into SEARCH or SETTLE.
    assign w_tmr_load = (w_state_next != r_state) &&
                        ((w_state_next == SEARCH) || (w_state_next == SETTLE));
    assign w_tmr_val  = (w_state_next == SEARCH) ? CNT_W'(timeout_lim) : CNT_W'(SETTLE_CYC);
    assign w_tmr_en   = (r_state == SEARCH) || (r_state == SETTLE);

    hold_timer #(
        .W (CNT_W)
    ) u_hold_timer (
        .i_clk      (clock),
        .i_srst     (sclr),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_fault_code;
        w_dir_next   = r_dir;
        case (r_state)
            IDLE, DONE, FAULT: begin
                if (start) begin
                    w_state_next = WAIT_RDY;
                    w_code_next  = FLT_NONE;
                    w_dir_next   = search_dir;
                end
            end
            default: begin
                if (abort) begin
                    w_state_next = FAULT;
                    w_code_next  = FLT_ABORT;
                end else if (enc_error && w_enc_phase) begin
                    w_state_next = FAULT;
                    w_code_next  = FLT_ENC;
                end else if ((r_state == SEARCH) && w_expire) begin
                    w_state_next = FAULT;
                    w_code_next  = FLT_TMO;
                end else begin
                    case (r_state)
                        WAIT_RDY: if (enc_ready) w_state_next = CLR_Z;
                        CLR_Z:    w_state_next = SEARCH;
                        SEARCH:   if (Z_flag) w_state_next = SETTLE;
                        SETTLE:   if (w_expire) w_state_next = CALC;
                        CALC:     w_state_next = WR_LO;
                        WR_LO:    w_state_next = WR_HI;
                        WR_HI:    w_state_next = DONE;
                        default:  w_state_next = r_state;
                    endcase
                end
            end
        endcase
    end

    assign w_next_ena = !((w_state_next == IDLE) || (w_state_next == FAULT));
    assign w_next_wr  = (w_state_next == WR_LO) || (w_state_next == WR_HI);

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_state      <= IDLE;
            r_fault_code <= FLT_NONE;
            r_dir        <= 1'b0;
            r_preset     <= '0;
            r_enc_ena    <= 1'b0;
            r_enc_dir    <= 1'b0;
            r_z_clr      <= 1'b0;
            r_motor_run  <= 1'b0;
            r_addr       <= 1'b0;
            r_be         <= 2'b00;
            r_write      <= 1'b0;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fault_code <= w_code_next;
            r_dir        <= w_dir_next;
            if (w_state_next == CALC) begin
                r_preset <= w_preset_calc;
            end
            r_enc_ena    <= w_next_ena;
            r_enc_dir    <= w_next_ena ? w_dir_next : 1'b0;
            r_z_clr      <= (w_state_next == CLR_Z);
            r_motor_run  <= (w_state_next == SEARCH);
            r_write      <= w_next_wr;
            r_addr       <= (w_state_next == WR_HI) ? ADDR_HI : ADDR_LO;
            r_be         <= w_next_wr ? BE_ALL : 2'b00;
            if (w_state_next == WR_LO) begin
                r_data <= r_preset[15:0];
            end else if (w_state_next == WR_HI) begin
                r_data <= r_preset[31:16];
            end else begin
                r_data <= '0;
            end
            r_busy       <= is_busy(w_state_next);
            r_done       <= (w_state_next == DONE);
            r_fault      <= (w_state_next == FAULT);
        end
    end

    assign enc_ena    = r_enc_ena;
    assign enc_dir    = r_enc_dir;
    assign Z_clr      = r_z_clr;
    assign motor_run  = r_motor_run;
    assign addr       = r_addr;
    assign be         = r_be;
    assign write      = r_write;
    assign data       = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule

// File: doc/enc_home_ctrl.md
ENC_HOME_CTRL -- requirements
Module: enc_home_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_W, 24, width of the index-search timeout counter.
REQ-002 SHALL have parameter SETTLE_CYC, 256, clock cycles waited after motor stop before sampling the counter.
REQ-003 SHALL have port clock  input  1  single clock for the whole block.
REQ-004 SHALL have port sclr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports start / abort  input  1 each  single-cycle homing request / cancel.
REQ-006 SHALL have port search_dir  input  1  direction of the index search.
REQ-007 SHALL have port home_offset  input  32 signed  value the counter SHALL read at the index position.
REQ-008 SHALL have port timeout_lim  input  TIMEOUT_W  maximum SEARCH cycles.
REQ-009 SHALL have ports enc_ready, enc_error, Z_flag  input  1 each  encoder status.
REQ-010 SHALL have ports Z_pos, bidir_counter  input  32 signed each  encoder latched index position / live count.
REQ-011 SHALL have ports enc_ena, enc_dir, Z_clr, motor_run  output  1 each  encoder enable, encoder direction, index-flag clear, motion request.
REQ-012 SHALL have ports addr (1), be (2), write (1), data (16)  output  counter preset bus.
REQ-013 SHALL have ports busy, done, fault  output  1 each; fault_code  output  2.

Function
REQ-014 States SHALL be IDLE, WAIT_RDY, CLR_Z, SEARCH, SETTLE, CALC, WR_LO, WR_HI, DONE, FAULT.
REQ-015 IDLE -> WAIT_RDY on start; start outside IDLE/DONE/FAULT SHALL be ignored.
REQ-016 WAIT_RDY: enc_ena=1, enc_dir=search_dir (captured at start); -> CLR_Z when enc_ready=1.
REQ-017 CLR_Z: Z_clr=1 for exactly one cycle; -> SEARCH next cycle.
REQ-018 SEARCH: motor_run=1, timeout counter increments per cycle from 0; -> SETTLE on Z_flag=1; -> FAULT code 01 when counter equals timeout_lim before Z_flag.
REQ-019 SETTLE: motor_run=0 for SETTLE_CYC cycles, then -> CALC.
REQ-020 CALC: preset = home_offset + (bidir_counter - Z_pos), 32-bit two's-complement wrap, registered in one cycle.
REQ-021 WR_LO: write=1, addr=0, be=2'b11, data=preset[15:0] for one cycle; WR_HI: write=1, addr=1, be=2'b11, data=preset[31:16] for one cycle; -> DONE.
REQ-022 write SHALL be 0 in every other state; addr/be/data SHALL be 0 when write=0.
REQ-023 DONE: done=1, enc_ena stays 1; start re-enters WAIT_RDY and clears done.
REQ-024 enc_error=1 in WAIT_RDY..SETTLE SHALL -> FAULT code 10; abort in any busy state SHALL -> FAULT code 11; abort has priority over enc_error, enc_error over timeout, all over normal transitions in the same cycle.
REQ-025 FAULT: fault=1, motor_run=0, enc_ena=0, fault_code held; start clears fault and -> WAIT_RDY.
REQ-026 busy SHALL be 1 in all states except IDLE, DONE, FAULT.
REQ-027 Latency start -> done with enc_ready and Z_flag already high: 1+1+1+1+SETTLE_CYC+1+2 cycles deterministic.
REQ-028 motor_run SHALL drop in the same cycle the FSM leaves SEARCH.

Reset
REQ-029 sclr SHALL force IDLE and all outputs to 0 (fault_code=00, data=0) on the next clock edge, regardless of state, including mid-write.
REQ-030 Timeout and settle counters and preset register SHALL reset to 0.

Structure
REQ-031 State enum, fault code constants (FLT_NONE=00, FLT_TMO=01, FLT_ENC=10, FLT_ABORT=11) and bus address constants SHALL live in shared package enc_home_pkg.
REQ-032 One sub-module, hold_timer (loadable down-counter with expire flag), SHALL serve both SEARCH timeout and SETTLE wait.

Verification
REQ-033 enc_ready=1, Z_flag at SEARCH cycle 10, Z_pos=100, bidir_counter=130, home_offset=0 -> WR_LO data=0x001E, WR_HI data=0x0000, done=1.
REQ-034 home_offset=-5, Z_pos=0x7FFFFFFF, bidir_counter=0x80000002 -> preset=0xFFFFFFFE (wrap), two writes 0xFFFE then 0xFFFF.
REQ-035 timeout_lim=50, Z_flag never -> fault=1, fault_code=01 at SEARCH cycle 50, motor_run=0 same cycle.
REQ-036 abort and enc_error asserted same cycle in SEARCH -> fault_code=11.
REQ-037 sclr asserted in WR_LO -> next cycle IDLE, write=0, busy=0, no WR_HI issued.
REQ-038 start while busy in SEARCH -> ignored; Z_clr pulses exactly once per homing run.
